// File: rtl/spongent_round_ctrl_if.sv
// Host-side handshake bundle for the Spongent round controller:
// permutation request/accept on one side, result valid/accept on the other.
interface spongent_round_ctrl_if #(
    parameter int STATE_W = 264
);
    logic               start;
    logic [STATE_W-1:0] state_in;
    logic               ready;
    logic               out_valid;
    logic               out_ready;
    logic [STATE_W-1:0] state_out;

    modport master (
        output start, state_in, out_ready,
        input  ready, out_valid, state_out
    );

    modport slave (
        input  start, state_in, out_ready,
        output ready, out_valid, state_out
    );
endinterface

// File: rtl/spongent_round_ctrl.sv
// Spongent permutation sequencer: owns the state register, the lCounter LFSR
// and the round counter, and drives the external byte-serial sBox/pLayer datapath.
module spongent_round_ctrl #(
    parameter int               STATE_W = 264,
    parameter int               NSBOX   = 33,
    parameter int               ROUNDS  = 140,
    parameter int               LC_W    = 8,
    parameter logic [LC_W-1:0]  LC_INIT = 8'h9E
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    spongent_round_ctrl_if.slave bus,
    output logic [STATE_W-1:0]   o_sbox_in,
    input  logic [STATE_W-1:0]   i_sbox_out,
    output logic [STATE_W-1:0]   o_pl_state,
    output logic [31:0]          o_pl_index,
    input  logic [STATE_W-1:0]   i_pl_out,
    output logic [7:0]           o_round_idx
);
    localparam int IDX_W = (NSBOX > 1) ? $clog2(NSBOX) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NSBOX - 1);
    localparam logic [7:0]       ROUND_LAST = 8'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LC   = 3'd1,
        S_SB   = 3'd2,
        S_PL   = 3'd3,
        S_DONE = 3'd4
    } fsm_t;

    fsm_t               r_fsm;
    fsm_t               w_fsm_nxt;
    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [LC_W-1:0]    r_lc;
    logic [LC_W-1:0]    w_lc_nxt;
    logic [7:0]         r_round;
    logic [7:0]         w_round_nxt;
    logic [IDX_W-1:0]   r_pl_idx;
    logic [IDX_W-1:0]   w_pl_idx_nxt;
    logic               r_ready;
    logic               r_out_valid;

    function automatic logic [LC_W-1:0] bitrev(input logic [LC_W-1:0] v);
        logic [LC_W-1:0] r;
        for (int i = 0; i < LC_W; i++) begin
            r[i] = v[LC_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [LC_W-1:0] lc_step(input logic [LC_W-1:0] v);
        return {v[LC_W-2:0], v[LC_W-1] ^ v[3] ^ v[2] ^ v[1]};
    endfunction

    // Next-state and datapath-update decode for every FSM phase.
    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_state_nxt  = r_state;
        w_lc_nxt     = r_lc;
        w_round_nxt  = r_round;
        w_pl_idx_nxt = r_pl_idx;
        case (r_fsm)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = bus.state_in;
                    w_lc_nxt    = LC_INIT;
                    w_round_nxt = 8'd0;
                    w_fsm_nxt   = S_LC;
                end else begin
                    w_fsm_nxt   = S_IDLE;
                end
            end
            S_LC: begin
                w_state_nxt[LC_W-1:0]         = r_state[LC_W-1:0] ^ r_lc;
                w_state_nxt[STATE_W-1 -: LC_W] = r_state[STATE_W-1 -: LC_W] ^ bitrev(r_lc);
                w_lc_nxt  = lc_step(r_lc);
                w_fsm_nxt = S_SB;
            end
            S_SB: begin
                w_state_nxt  = i_sbox_out;
                w_pl_idx_nxt = '0;
                w_fsm_nxt    = S_PL;
            end
            S_PL: begin
                // State is held during the sweep; only the last index captures pl_out.
                if (r_pl_idx == IDX_LAST) begin
                    w_state_nxt  = i_pl_out;
                    w_pl_idx_nxt = '0;
                    if (r_round == ROUND_LAST) begin
                        w_fsm_nxt = S_DONE;
                    end else begin
                        w_round_nxt = r_round + 8'd1;
                        w_fsm_nxt   = S_LC;
                    end
                end else begin
                    w_pl_idx_nxt = r_pl_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_fsm_nxt = S_IDLE;
                end else begin
                    w_fsm_nxt = S_DONE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; ready/out_valid are registered from the next FSM state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_lc        <= LC_INIT;
            r_round     <= 8'd0;
            r_pl_idx    <= '0;
            r_ready     <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_lc        <= w_lc_nxt;
            r_round     <= w_round_nxt;
            r_pl_idx    <= w_pl_idx_nxt;
            r_ready     <= (w_fsm_nxt == S_IDLE);
            r_out_valid <= (w_fsm_nxt == S_DONE);
        end
    end

    assign bus.ready     = r_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.state_out = r_state;
    assign o_sbox_in     = r_state;
    assign o_pl_state    = r_state;
    assign o_pl_index    = {{(32-IDX_W){1'b0}}, r_pl_idx};
    assign o_round_idx   = r_round;
endmodule

// File: tb/tb_spongent_round_ctrl.sv
// Bench for spongent_round_ctrl: a 1-round instance with identity datapath and
// a 140-round instance with a Spongent sBox/pLayer model checked against a golden model.
module tb_spongent_round_ctrl;
    localparam int SW = 264;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spongent_round_ctrl_if #(.STATE_W(SW)) if1 ();
    spongent_round_ctrl_if #(.STATE_W(SW)) if2 ();

    logic [SW-1:0] sb_in1, pl_st1, sb_in2, pl_st2, sb_out2, pl_out2;
    logic [31:0]   pli1, pli2;
    logic [7:0]    ri1, ri2;

    int n_pass  = 0;
    int n_total = 0;
    int pl_last_cnt = 0;
    int sweep_bad   = 0;
    logic [31:0] prev_idx = 32'd0;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hE;  4'h1: return 4'hD;  4'h2: return 4'hB;  4'h3: return 4'h0;
            4'h4: return 4'h2;  4'h5: return 4'h1;  4'h6: return 4'h4;  4'h7: return 4'hF;
            4'h8: return 4'h7;  4'h9: return 4'hA;  4'hA: return 4'h8;  4'hB: return 4'h5;
            4'hC: return 4'h9;  4'hD: return 4'hC;  4'hE: return 4'h3;  default: return 4'h6;
        endcase
    endfunction

    function automatic logic [SW-1:0] sbox_fn(input logic [SW-1:0] s);
        logic [SW-1:0] o;
        for (int i = 0; i < SW / 4; i++) o[4*i +: 4] = sbox4(s[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [SW-1:0] pl_fn(input logic [SW-1:0] s);
        logic [SW-1:0] o;
        for (int j = 0; j < SW - 1; j++) o[(j * (SW / 4)) % (SW - 1)] = s[j];
        o[SW-1] = s[SW-1];
        return o;
    endfunction

    function automatic logic [SW-1:0] golden(input logic [SW-1:0] din, input int rounds);
        logic [SW-1:0] s;
        logic [7:0]    lc;
        logic [7:0]    rv;
        s  = din;
        lc = 8'h9E;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 8; i++) rv[i] = lc[7-i];
            s[7:0]     = s[7:0] ^ lc;
            s[SW-1 -: 8] = s[SW-1 -: 8] ^ rv;
            lc = {lc[6:0], lc[7] ^ lc[3] ^ lc[2] ^ lc[1]};
            s = pl_fn(sbox_fn(s));
        end
        return s;
    endfunction

    assign sb_out2 = sbox_fn(sb_in2);
    assign pl_out2 = pl_fn(pl_st2);

    spongent_round_ctrl #(.STATE_W(SW), .NSBOX(33), .ROUNDS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .bus(if1),
        .o_sbox_in(sb_in1), .i_sbox_out(sb_in1),
        .o_pl_state(pl_st1), .o_pl_index(pli1), .i_pl_out(pl_st1),
        .o_round_idx(ri1)
    );

    spongent_round_ctrl #(.STATE_W(SW), .NSBOX(33), .ROUNDS(140)) dut2 (
        .i_clk(clk), .i_rst(rst), .bus(if2),
        .o_sbox_in(sb_in2), .i_sbox_out(sb_out2),
        .o_pl_state(pl_st2), .o_pl_index(pli2), .i_pl_out(pl_out2),
        .o_round_idx(ri2)
    );

    // Sweep monitor: counts last-index cycles and flags non-sequential indices.
    always @(negedge clk) begin
        if (pli2 == 32'd32) pl_last_cnt <= pl_last_cnt + 1;
        if (pli2 != 32'd0 && pli2 != prev_idx + 32'd1) sweep_bad <= sweep_bad + 1;
        prev_idx <= pli2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_valid2(output int n);
        n = 0;
        while (!if2.out_valid && n < 6000) begin
            tick;
            n++;
        end
    endtask

    typedef struct {
        logic [SW-1:0] din;
        logic [SW-1:0] exp;
    } vec_t;

    vec_t vt[4];

    initial begin
        int n, c0, b0, hold_bad;
        logic [SW-1:0] x, y, gx, gy, so;

        vt[0] = '{din: '0,                                   exp: {8'h79, 248'd0, 8'h9E}};
        vt[1] = '{din: {33{8'hFF}},                          exp: {8'h86, {31{8'hFF}}, 8'h61}};
        vt[2] = '{din: {8'h79, 248'd0, 8'h9E},               exp: '0};
        vt[3] = '{din: {8'h79, {31{8'h12}}, 8'h00},          exp: {8'h00, {31{8'h12}}, 8'h9E}};

        x  = {8'h01, {16{16'hC35A}}};
        y  = {33{8'h5A}} ^ {8'h80, 256'd0};
        gx = golden(x, 140);
        gy = golden(y, 140);

        rst = 1'b1;
        if1.start = 1'b0; if1.state_in = '0; if1.out_ready = 1'b0;
        if2.start = 1'b0; if2.state_in = '0; if2.out_ready = 1'b0;
        tick;
        tick;
        check("rst_ready1", if1.ready, 1);
        check("rst_valid1", if1.out_valid, 0);
        check("rst_state1", if1.state_out, 0);
        check("rst_plidx1", pli1, 0);
        check("rst_ready2", if2.ready, 1);
        check("rst_valid2", if2.out_valid, 0);
        check("rst_state2", if2.state_out, 0);
        check("rst_round2", ri2, 0);
        rst = 1'b0;
        tick;

        // Single-round vectors: out_ready held high throughout to show it is ignored outside DONE.
        for (int v = 0; v < 4; v++) begin
            if1.state_in  = vt[v].din;
            if1.start     = 1'b1;
            if1.out_ready = 1'b1;
            tick;
            if1.start = 1'b0;
            check($sformatf("v%0d_busy", v), if1.ready, 0);
            n = 0;
            while (!if1.out_valid && n < 100) begin
                tick;
                n++;
            end
            check($sformatf("v%0d_latency", v), n, 35);
            check($sformatf("v%0d_state", v), if1.state_out, vt[v].exp);
            check($sformatf("v%0d_round", v), ri1, 0);
            tick;
            check($sformatf("v%0d_ready", v), if1.ready, 1);
            if1.out_ready = 1'b0;
        end

        // 140 rounds, start held high, DONE held for 10 cycles, then back-to-back restart.
        if2.state_in = x;
        if2.start    = 1'b1;
        tick;
        c0 = pl_last_cnt;
        b0 = sweep_bad;
        wait_valid2(n);
        check("r140_latency", n, 4900);
        check("r140_state", if2.state_out, gx);
        check("r140_round", ri2, 139);
        check("r140_plcount", pl_last_cnt - c0, 140);
        check("r140_sweep", sweep_bad - b0, 0);
        so = if2.state_out;
        hold_bad = 0;
        repeat (10) begin
            tick;
            if (if2.out_valid !== 1'b1 || if2.state_out !== so || if2.ready !== 1'b0) hold_bad++;
        end
        check("done_hold", hold_bad, 0);
        if2.out_ready = 1'b1;
        tick;
        check("done_release_ready", if2.ready, 1);
        check("done_release_valid", if2.out_valid, 0);
        if2.out_ready = 1'b0;
        if2.state_in  = y;
        tick;
        check("b2b_accept", if2.ready, 0);
        if2.start = 1'b0;
        wait_valid2(n);
        check("b2b_latency", n, 4900);
        check("b2b_state", if2.state_out, gy);
        if2.out_ready = 1'b1;
        tick;
        if2.out_ready = 1'b0;
        check("b2b_ready", if2.ready, 1);

        // Abort during round 3 at pl_index 17, then a clean rerun.
        if2.state_in = x;
        if2.start    = 1'b1;
        tick;
        if2.start = 1'b0;
        n = 0;
        while (!(ri2 == 8'd3 && pli2 == 32'd17) && n < 6000) begin
            tick;
            n++;
        end
        check("abort_reached", (n < 6000) ? 1 : 0, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_ready", if2.ready, 1);
        check("abort_valid", if2.out_valid, 0);
        check("abort_plidx", pli2, 0);
        check("abort_state", if2.state_out, 0);
        check("abort_round", ri2, 0);
        if2.start = 1'b1;
        tick;
        if2.start = 1'b0;
        wait_valid2(n);
        check("rerun_latency", n, 4900);
        check("rerun_state", if2.state_out, gx);
        if2.out_ready = 1'b1;
        tick;
        if2.out_ready = 1'b0;
        check("rerun_ready", if2.ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
